// File: rtl/analog_to_mixed_serializer_pkg.sv
// rtl/analog_to_mixed_serializer_pkg.sv - Shared constants, sizing helper and FSM states for the byte serializer
package psec5_mixed_pkg;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_ch(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/analog_to_mixed_serializer_if.sv
// rtl/analog_to_mixed_serializer_if.sv - Snapshot, byte stream and status bundle of the serializer
interface analog_to_mixed_serializer_if
  import psec5_mixed_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 50
);
  localparam int BPC        = bytes_per_ch(CH_WIDTH);
  localparam int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_IDX_W = (BPC > 1) ? $clog2(BPC) : 1;

  logic                         load_i;
  logic [NUM_CH*CH_WIDTH-1:0]   ch_data_i;
  logic [NUM_CH-1:0]            ch_en_i;
  logic                         ready_i;
  logic                         clr_ovr_i;
  logic [BYTE_W-1:0]            byte_o;
  logic [CH_IDX_W-1:0]          ch_idx_o;
  logic [BYTE_IDX_W-1:0]        byte_idx_o;
  logic                         valid_o;
  logic                         last_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         overrun_o;

  modport master (
    output load_i, ch_data_i, ch_en_i, ready_i, clr_ovr_i,
    input  byte_o, ch_idx_o, byte_idx_o, valid_o, last_o, busy_o, done_o, overrun_o
  );

  modport slave (
    input  load_i, ch_data_i, ch_en_i, ready_i, clr_ovr_i,
    output byte_o, ch_idx_o, byte_idx_o, valid_o, last_o, busy_o, done_o, overrun_o
  );

endinterface

// File: rtl/analog_to_mixed_serializer_ch_next_sel.sv
// rtl/analog_to_mixed_serializer_ch_next_sel.sv - Lowest enabled channel, either overall or strictly above idx
module ch_next_sel #(
  parameter int NUM_CH   = 8,
  parameter int CH_IDX_W = 3
) (
  input  logic [NUM_CH-1:0]   mask,
  input  logic [CH_IDX_W-1:0] idx,
  input  logic                first,
  output logic [CH_IDX_W-1:0] next_idx,
  output logic                found
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(idx)))) begin
        next_idx = CH_IDX_W'(k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/analog_to_mixed_serializer.sv
// rtl/analog_to_mixed_serializer.sv - Snapshots channel words and streams their little-endian bytes over valid/ready
module analog_to_mixed_serializer
  import psec5_mixed_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  analog_to_mixed_serializer_if.slave bus
);

  localparam int BPC        = bytes_per_ch(CH_WIDTH);
  localparam int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_IDX_W = (BPC > 1) ? $clog2(BPC) : 1;

  state_e                     state_q, state_d;
  logic [NUM_CH*CH_WIDTH-1:0] shadow_q;
  logic [NUM_CH-1:0]          en_q;
  logic [CH_IDX_W-1:0]        ch_q;
  logic [BYTE_IDX_W-1:0]      byte_q;
  logic                       overrun_q;

  logic                       init_found, adv_found;
  logic [CH_IDX_W-1:0]        init_idx, adv_idx;
  logic                       valid, busy, last_byte, xfer;
  logic [CH_WIDTH-1:0]        ch_word;
  logic [BPC*BYTE_W-1:0]      padded;
  logic [BYTE_W-1:0]          cur_byte;

  ch_next_sel #(.NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W)) u_first_sel (
    .mask     (bus.ch_en_i),
    .idx      ({CH_IDX_W{1'b0}}),
    .first    (1'b1),
    .next_idx (init_idx),
    .found    (init_found)
  );

  ch_next_sel #(.NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W)) u_adv_sel (
    .mask     (en_q),
    .idx      (ch_q),
    .first    (1'b0),
    .next_idx (adv_idx),
    .found    (adv_found)
  );

  assign valid     = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign last_byte = (byte_q == BYTE_IDX_W'(BPC - 1));
  assign xfer      = valid & bus.ready_i;
  assign ch_word   = shadow_q[int'(ch_q)*CH_WIDTH +: CH_WIDTH];

  // Bits above CH_WIDTH in the final byte read as zero.
  always_comb begin
    padded                 = '0;
    padded[CH_WIDTH-1:0]   = ch_word;
  end

  assign cur_byte = padded[int'(byte_q)*BYTE_W +: BYTE_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.load_i) state_d = init_found ? SEND : DONE;
      SEND: if (xfer && last_byte && !adv_found) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      en_q      <= '0;
      ch_q      <= '0;
      byte_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.load_i) begin
        shadow_q <= bus.ch_data_i;
        en_q     <= bus.ch_en_i;
        ch_q     <= init_idx;
        byte_q   <= '0;
      end else if (xfer) begin
        if (last_byte) begin
          byte_q <= '0;
          if (adv_found) ch_q <= adv_idx;
        end else begin
          byte_q <= byte_q + BYTE_IDX_W'(1);
        end
      end
      // A fresh overrun outranks a simultaneous clear.
      if (bus.load_i && busy) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_ovr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.valid_o    = valid;
  assign bus.byte_o     = valid ? cur_byte : '0;
  assign bus.ch_idx_o   = valid ? ch_q : '0;
  assign bus.byte_idx_o = valid ? byte_q : '0;
  assign bus.last_o     = valid & last_byte & ~adv_found;
  assign bus.busy_o     = busy;
  assign bus.done_o     = (state_q == DONE);
  assign bus.overrun_o  = overrun_q;

endmodule
